// File: rtl/sr_ctx.sv
// Special-register context save/restore engine: streams the SR file out
// over a valid/ready port on save, and writes it back from a stream on restore.
`ifndef HBIT_DATA
`define HBIT_DATA 31
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif
`ifndef HBIT_SR
`define HBIT_SR 3
`endif

module sr_ctx #(
  parameter int P_NUM_SR = `HBIT_SR + 1
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_save_req,
  input  logic                  iw_restore_req,
  input  logic                  iw_abort,
  output logic                  ow_busy,
  output logic                  ow_done,
  output logic [`HBIT_TGT_GP:0] ow_rd_addr,
  input  logic [`HBIT_DATA:0]   iw_rd_data,
  output logic [`HBIT_TGT_GP:0] ow_wr_addr,
  output logic [`HBIT_DATA:0]   ow_wr_data,
  output logic                  ow_wr_en,
  output logic                  ow_tx_valid,
  input  logic                  iw_tx_ready,
  output logic [`HBIT_DATA:0]   ow_tx_data,
  input  logic                  iw_rx_valid,
  output logic                  ow_rx_ready,
  input  logic [`HBIT_DATA:0]   iw_rx_data
);
  localparam int AW = `HBIT_TGT_GP + 1;
  localparam int DW = `HBIT_DATA + 1;
  // One extra count value so the index can reach P_NUM_SR without wrapping.
  localparam int IW = $clog2(P_NUM_SR + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(P_NUM_SR - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SAVE, ST_SAVE_DRAIN, ST_RESTORE, ST_RESTORE_LAST, ST_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          tx_valid_q, tx_valid_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          tx_hs, rx_hs, tx_load;

  assign ow_busy     = (state_q != ST_IDLE);
  assign ow_done     = (state_q == ST_DONE);
  // Ready is withheld during abort so no word is accepted that would then be dropped.
  assign ow_rx_ready = (state_q == ST_RESTORE) && !iw_abort;
  assign ow_rd_addr  = (state_q == ST_SAVE) ? AW'(idx_q) : '0;
  assign ow_tx_valid = tx_valid_q;
  assign ow_tx_data  = tx_data_q;
  assign ow_wr_en    = wr_en_q;
  assign ow_wr_addr  = wr_addr_q;
  assign ow_wr_data  = wr_data_q;

  assign tx_hs   = tx_valid_q && iw_tx_ready;
  assign rx_hs   = ow_rx_ready && iw_rx_valid;
  assign tx_load = !tx_valid_q || iw_tx_ready;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d    = state_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (state_q != ST_IDLE && iw_abort) begin
      state_d    = ST_IDLE;
      tx_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!iw_abort) begin
            if (iw_save_req) begin
              state_d = ST_SAVE;
              idx_d   = '0;
            end else if (iw_restore_req) begin
              state_d = ST_RESTORE;
              idx_d   = '0;
            end
          end
        end
        ST_SAVE: begin
          if (tx_load) begin
            tx_data_d  = iw_rd_data;
            tx_valid_d = 1'b1;
            idx_d      = idx_q + 1'b1;
            if (idx_q == LAST_IDX) state_d = ST_SAVE_DRAIN;
          end
        end
        ST_SAVE_DRAIN: begin
          if (tx_hs) begin
            tx_valid_d = 1'b0;
            state_d    = ST_DONE;
          end
        end
        ST_RESTORE: begin
          if (rx_hs) begin
            wr_en_d   = 1'b1;
            wr_addr_d = AW'(idx_q);
            wr_data_d = iw_rx_data;
            idx_d     = idx_q + 1'b1;
            if (idx_q == LAST_IDX) state_d = ST_RESTORE_LAST;
          end
        end
        ST_RESTORE_LAST: state_d = ST_DONE;
        ST_DONE:         state_d = ST_IDLE;
        default:         state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end
endmodule

// File: tb/tb_sr_ctx.sv
// Self-checking bench for sr_ctx: SR file model, expected-contents array and
// directed plus randomized save/restore/abort/reset sequences.
`ifndef HBIT_DATA
`define HBIT_DATA 31
`endif
`ifndef HBIT_TGT_GP
`define HBIT_TGT_GP 3
`endif

module tb_sr_ctx;
  localparam int P  = 4;
  localparam int AW = `HBIT_TGT_GP + 1;
  localparam int DW = `HBIT_DATA + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          save_req = 1'b0, restore_req = 1'b0, abort = 1'b0;
  logic          busy, done, wr_en, tx_valid, rx_ready;
  logic          tx_ready = 1'b0, rx_valid = 1'b0;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data, wr_data, tx_data;
  logic [DW-1:0] rx_data = '0;

  logic [DW-1:0] sr_mem  [2**AW];
  logic [DW-1:0] exp_mem [2**AW];
  logic [DW-1:0] rx_words [P];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  assign rd_data = sr_mem[rd_addr];

  sr_ctx #(.P_NUM_SR(P)) dut (
    .iw_clk(clk), .iw_rst(rst),
    .iw_save_req(save_req), .iw_restore_req(restore_req), .iw_abort(abort),
    .ow_busy(busy), .ow_done(done),
    .ow_rd_addr(rd_addr), .iw_rd_data(rd_data),
    .ow_wr_addr(wr_addr), .ow_wr_data(wr_data), .ow_wr_en(wr_en),
    .ow_tx_valid(tx_valid), .iw_tx_ready(tx_ready), .ow_tx_data(tx_data),
    .iw_rx_valid(rx_valid), .ow_rx_ready(rx_ready), .iw_rx_data(rx_data)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the SR file model commits whatever write the DUT presented.
  task automatic tick();
    logic we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    we = wr_en; wa = wr_addr; wd = wr_data;
    @(posedge clk);
    #1;
    if (we === 1'b1) sr_mem[wa] = wd;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_rx_ready"}, rx_ready, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0; 2: random ready.
  task automatic run_save(input int mode, input bit with_restore);
    int got = 0, hs_first = -1, hs_last = -1, done_cyc = -1;
    bit stalled = 1'b0;
    logic [DW-1:0] held = '0;
    save_req = 1'b1;
    restore_req = with_restore;
    tick();
    save_req = 1'b0;
    for (int c = 0; c < 200 && done_cyc < 0; c++) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (c % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (stalled) begin
        check("save_stall_valid", tx_valid, 1);
        check("save_stall_data", tx_data, held);
      end
      check("save_no_wr", wr_en, 0);
      check("save_no_rx_ready", rx_ready, 0);
      check("save_rd_addr_range", rd_addr < P, 1);
      if (tx_valid === 1'b1 && tx_ready) begin
        check("save_word_count", got < P, 1);
        if (got < P) check("save_word", tx_data, exp_mem[got]);
        got++;
        hs_last = cyc;
        if (hs_first < 0) hs_first = cyc;
      end
      stalled = (tx_valid === 1'b1) && !tx_ready;
      held = tx_data;
      if (done === 1'b1) done_cyc = cyc;
      tick();
    end
    restore_req = 1'b0;
    tx_ready = 1'b0;
    check("save_done_seen", done_cyc >= 0, 1);
    check("save_words", got, P);
    check("save_done_lat", done_cyc - hs_last, 1);
    if (mode == 0) check("save_back_to_back", hs_last - hs_first, P - 1);
    check("save_done_pulse", done, 0);
    check("save_busy_after", busy, 0);
  endtask

  // abort_after > 0 raises abort in the cycle after that many handshakes.
  task automatic run_restore(input int abort_after);
    int hs = 0, writes = 0, done_cyc = -1, last_hs = -1;
    bit pend = 1'b0, aborted = 1'b0;
    logic [AW-1:0] pa = '0;
    logic [DW-1:0] pd = '0;
    restore_req = 1'b1;
    tick();
    restore_req = 1'b0;
    for (int c = 0; c < 200 && done_cyc < 0 && !aborted; c++) begin
      abort = (abort_after > 0 && hs == abort_after);
      rx_valid = (hs < P && !abort) ? ($urandom_range(0, 2) != 0) : 1'b0;
      rx_data = (hs < P) ? rx_words[hs] : DW'($urandom);
      #1;
      check("rst_wr_en", wr_en, pend);
      if (pend) begin
        check("rst_wr_addr", wr_addr, pa);
        check("rst_wr_data", wr_data, pd);
        writes++;
      end
      check("rst_rd_addr_zero", rd_addr, 0);
      if (!abort) check("rst_rx_ready", rx_ready, (hs < P));
      pend = 1'b0;
      if (rx_valid && rx_ready === 1'b1) begin
        pend = 1'b1;
        pa = AW'(hs);
        pd = rx_data;
        exp_mem[hs] = rx_data;
        hs++;
        last_hs = cyc;
      end
      if (done === 1'b1) done_cyc = cyc;
      aborted = abort;
      tick();
    end
    abort = 1'b0;
    rx_valid = 1'b0;
    check("rst_busy_after", busy, 0);
    check("rst_done_after", done, 0);
    check("rst_wr_after", wr_en, 0);
    if (abort_after > 0) begin
      check("abort_writes", writes, abort_after);
      for (int i = 0; i < 3; i++) begin
        tick();
        check("abort_no_done", done, 0);
        check("abort_no_wr", wr_en, 0);
      end
    end else begin
      check("rst_writes", writes, P);
      check("rst_done_lat", done_cyc - last_hs, 2);
    end
    for (int i = 0; i < P; i++) check("rst_sr_contents", sr_mem[i], exp_mem[i]);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      sr_mem[i] = '0;
      exp_mem[i] = '0;
    end
    for (int i = 0; i < P; i++) begin
      sr_mem[i] = DW'((i + 1) * 'h11);
      exp_mem[i] = DW'((i + 1) * 'h11);
    end

    // Reset state
    #12;
    check_all_zero("reset");
    #10;
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);

    // Saves: full throughput, stalled ready, both requests together
    run_save(0, 1'b0);
    run_save(1, 1'b0);
    run_save(0, 1'b1);

    // Restore of 0xA0..0xA3 with gaps, then save back
    for (int i = 0; i < P; i++) rx_words[i] = DW'('hA0 + i);
    run_restore(0);
    run_save(2, 1'b0);

    // Abort after second restore handshake
    for (int i = 0; i < P; i++) rx_words[i] = DW'('hB0 + i);
    run_restore(2);

    // Abort in IDLE blocks a same-cycle request
    abort = 1'b1;
    save_req = 1'b1;
    tick();
    abort = 1'b0;
    save_req = 1'b0;
    check("idle_abort_blocks", busy, 0);
    tick();
    check("idle_abort_still", busy, 0);

    // Asynchronous reset in the middle of a save
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    tx_ready = 1'b0;
    tick();
    tick();
    check("pre_reset_valid", tx_valid, 1);
    check("pre_reset_data", tx_data, exp_mem[0]);
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    tick();
    rst = 1'b0;
    run_save(0, 1'b0);

    // Randomized restore/save rounds
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < P; i++) rx_words[i] = DW'($urandom);
      run_restore(0);
      run_save(2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
